// File: rtl/nf10_input_arbiter_n.sv
// N-port AXI4-Stream input arbiter: merges slave streams into one master stream, packet at a time.
// Latency: 1 cycle arbitration (IDLE), 1 cycle slave-accept to master-present via output register.
// Backpressure: m_axis_tready low holds the output register and drops the granted s_axis_tready.
// Optional INPUT_ARB_PKT_CNT_EN: per-port forwarded-packet counters on pkt_cnt (tied to 0 otherwise).
module nf10_input_arbiter_n #(
  parameter int C_NUM_PORTS        = 5,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_ARB_MODE         = 0
) (
  input  logic                                            axi_aclk,
  input  logic                                            axi_reset,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [C_NUM_PORTS*(C_AXIS_DATA_WIDTH/8)-1:0]    s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                          s_axis_tvalid,
  output logic [C_NUM_PORTS-1:0]                          s_axis_tready,
  input  logic [C_NUM_PORTS-1:0]                          s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]                    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                   m_axis_tuser,
  output logic                                            m_axis_tvalid,
  input  logic                                            m_axis_tready,
  output logic                                            m_axis_tlast,
  output logic [C_NUM_PORTS*32-1:0]                       pkt_cnt
);

  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int IW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

  typedef enum logic {IDLE, PKT} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [C_NUM_PORTS-1:0]        r_grant;
  logic [IW-1:0]                 r_gidx;
  logic [IW-1:0]                 r_last;
  logic [IW-1:0]                 w_win;
  logic [C_NUM_PORTS-1:0]        w_win_oh;
  logic                          w_any_vld;
  logic                          w_out_rdy;
  logic                          w_acc;
  logic                          w_rel;

  logic [C_AXIS_DATA_WIDTH-1:0]  r_m_data;
  logic [SW-1:0]                 r_m_strb;
  logic [C_AXIS_TUSER_WIDTH-1:0] r_m_user;
  logic                          r_m_vld;
  logic                          r_m_last;

  assign w_any_vld = |s_axis_tvalid;
  // The output register can take a beat when empty or being drained this cycle.
  assign w_out_rdy = ~r_m_vld | m_axis_tready;
  assign s_axis_tready = (r_state == PKT && w_out_rdy) ? r_grant : '0;
  assign w_acc = (r_state == PKT) & w_out_rdy & s_axis_tvalid[r_gidx];
  assign w_rel = w_acc & s_axis_tlast[r_gidx];

  // Winner selection: lowest index in fixed mode, else first valid after last winner (reverse scan so the nearest wins).
  always_comb begin
    w_win    = '0;
    w_win_oh = '0;
    if (C_ARB_MODE == 1) begin
      for (int i = C_NUM_PORTS - 1; i >= 0; i--) begin
        if (s_axis_tvalid[i]) w_win = IW'(i);
      end
    end else begin
      for (int off = C_NUM_PORTS; off >= 1; off--) begin
        if (s_axis_tvalid[(int'(r_last) + off) % C_NUM_PORTS])
          w_win = IW'((int'(r_last) + off) % C_NUM_PORTS);
      end
    end
    w_win_oh[w_win] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // FSM next state: IDLE arbitrates, PKT holds until the granted tlast beat is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_vld) w_state_nxt = PKT;
      PKT:     if (w_rel)     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant, granted index and round-robin pointer; grant drops once the packet is released.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(C_NUM_PORTS - 1);
    end else if (r_state == IDLE && w_any_vld) begin
      r_grant <= w_win_oh;
      r_gidx  <= w_win;
      r_last  <= w_win;
    end else if (w_rel) begin
      r_grant <= '0;
    end
  end

  // Output register: loads an accepted slave beat, holds while stalled, empties when drained.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_m_vld  <= 1'b0;
      r_m_last <= 1'b0;
      r_m_data <= '0;
      r_m_strb <= '0;
      r_m_user <= '0;
    end else if (w_out_rdy) begin
      r_m_vld <= w_acc;
      if (w_acc) begin
        r_m_last <= s_axis_tlast[r_gidx];
        r_m_data <= s_axis_tdata[r_gidx*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        r_m_strb <= s_axis_tstrb[r_gidx*SW +: SW];
        r_m_user <= s_axis_tuser[r_gidx*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
      end
    end
  end

  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tstrb  = r_m_strb;
  assign m_axis_tuser  = r_m_user;

`ifdef INPUT_ARB_PKT_CNT_EN
  logic [IW-1:0]              r_m_src;
  logic [C_NUM_PORTS*32-1:0]  r_pkt_cnt;

  // Source port travels alongside each beat in the output register.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset)              r_m_src <= '0;
    else if (w_out_rdy & w_acc) r_m_src <= r_gidx;
  end

  // Count packets as their last beat leaves on the master side; counters wrap.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset)
      r_pkt_cnt <= '0;
    else if (r_m_vld & m_axis_tready & r_m_last)
      r_pkt_cnt[r_m_src*32 +: 32] <= r_pkt_cnt[r_m_src*32 +: 32] + 32'd1;
  end

  assign pkt_cnt = r_pkt_cnt;
`else
  assign pkt_cnt = '0;
`endif

endmodule
